// File: rtl/fft_mem_sequencer.sv
// Address sequencer for an in-place radix-2 FFT working memory: bit-reversed
// load, per-stage butterfly read/write-back addressing, natural-order unload.
module fft_mem_sequencer #(
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int BF_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            load_data,
  output logic [SIZE:0]   invert_adr,
  output logic            en_rd,
  output logic [SIZE:0]   rd_ptr,
  output logic            en_wr,
  output logic [SIZE:0]   wr_ptr,
  output logic [SIZE-2:0] tw_adr,
  output logic [SIZE-1:0] stage,
  output logic            unload,
  output logic            busy,
  output logic            done
);

  localparam int PW = SIZE + 1;
  localparam logic [SIZE-1:0] LAST_IDX   = SIZE'(N - 1);
  localparam logic [SIZE-1:0] DRAIN_END  = SIZE'(BF_LAT);
  localparam logic [SIZE-1:0] LAST_STAGE = SIZE'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t state, state_nx;

  logic [SIZE-1:0] ld_cnt;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] stage_q;

  logic [BF_LAT-1:0]         dl_en;
  logic [BF_LAT-1:0][PW-1:0] dl_ptr;

  logic [PW-1:0] b_w, span, pos, top, bot;

  // NOTE: state register only; all decisions live in the combinational process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   if (in_valid && ld_cnt == LAST_IDX) state_nx = S_CALC;
      S_CALC:   if (cnt == LAST_IDX) state_nx = S_DRAIN;
      S_DRAIN:  if (cnt == DRAIN_END)
                  state_nx = (stage_q == LAST_STAGE) ? S_UNLOAD : S_CALC;
      S_UNLOAD: if (cnt == LAST_IDX) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Counters: ld_cnt wraps naturally at N, cnt is shared by CALC/DRAIN/UNLOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt  <= '0;
      cnt     <= '0;
      stage_q <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_UNLOAD) && (cnt == LAST_IDX);
      unique case (state)
        S_IDLE: begin
          ld_cnt  <= '0;
          cnt     <= '0;
          stage_q <= '0;
        end
        S_LOAD: begin
          cnt <= '0;
          if (in_valid) ld_cnt <= ld_cnt + SIZE'(1);
        end
        S_CALC: cnt <= (cnt == LAST_IDX) ? '0 : cnt + SIZE'(1);
        S_DRAIN: begin
          if (cnt == DRAIN_END) begin
            cnt     <= '0;
            stage_q <= (stage_q == LAST_STAGE) ? '0 : stage_q + SIZE'(1);
          end else begin
            cnt <= cnt + SIZE'(1);
          end
        end
        S_UNLOAD: cnt <= cnt + SIZE'(1);
        default:  cnt <= '0;
      endcase
    end
  end

  // Butterfly addressing: cnt[SIZE-1:1] is the butterfly index, cnt[0] picks top/bottom.
  always_comb begin
    b_w  = PW'(cnt[SIZE-1:1]);
    span = PW'(1) << stage_q;
    pos  = b_w & (span - PW'(1));
    top  = ((b_w >> stage_q) << (stage_q + SIZE'(1))) | pos;
    bot  = top + span;
  end

  always_comb begin
    load_data = (state == S_LOAD) && in_valid;
    en_rd     = 1'b0;
    rd_ptr    = '0;
    tw_adr    = '0;
    unload    = 1'b0;
    for (int i = 0; i < SIZE; i++) invert_adr[i] = ld_cnt[SIZE-1-i];
    invert_adr[SIZE] = 1'b0;
    if (state == S_CALC) begin
      en_rd  = 1'b1;
      rd_ptr = cnt[0] ? bot : top;
      tw_adr = pos[SIZE-2:0] << (LAST_STAGE - stage_q);
    end else if (state == S_UNLOAD) begin
      en_rd  = 1'b1;
      unload = 1'b1;
      rd_ptr = {1'b0, cnt};
    end
  end

  // NOTE: the write-back delay line is reset so no stale write fires after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_en  <= '0;
      dl_ptr <= '0;
    end else begin
      dl_en[0]  <= en_rd && (state == S_CALC);
      dl_ptr[0] <= rd_ptr;
      for (int i = 1; i < BF_LAT; i++) begin
        dl_en[i]  <= dl_en[i-1];
        dl_ptr[i] <= dl_ptr[i-1];
      end
    end
  end

  assign en_wr  = dl_en[BF_LAT-1];
  assign wr_ptr = dl_ptr[BF_LAT-1];
  assign stage  = stage_q;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Scoreboard bench for fft_mem_sequencer (N=16): stimulus queues expected
// load/read/write/done events with their cycle numbers, a monitor pops and compares.
module tb_fft_mem_sequencer;

  localparam int N      = 16;
  localparam int SIZE   = 4;
  localparam int BF_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            load_data;
  logic [SIZE:0]   invert_adr;
  logic            en_rd;
  logic [SIZE:0]   rd_ptr;
  logic            en_wr;
  logic [SIZE:0]   wr_ptr;
  logic [SIZE-2:0] tw_adr;
  logic [SIZE-1:0] stage;
  logic            unload;
  logic            busy;
  logic            done;

  fft_mem_sequencer #(.N(N), .SIZE(SIZE), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .load_data(load_data), .invert_adr(invert_adr),
    .en_rd(en_rd), .rd_ptr(rd_ptr), .en_wr(en_wr), .wr_ptr(wr_ptr),
    .tw_adr(tw_adr), .stage(stage), .unload(unload), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ptr;
    int tw;
    int stg;
    bit unl;
    int cyc;
  } rd_exp_t;

  typedef struct {
    int ptr;
    int cyc;
  } wr_exp_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;
  int      ld_q[$];
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int      done_q[$];

  // Hand-computed bit-reversed load order for N=16.
  int bitrev_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_data && en_wr) unexpected("load_wr_overlap");
      if (unload && !en_rd) unexpected("unload_without_rd");
      if (load_data) begin
        if (ld_q.size() == 0) unexpected("load_data");
        else check("invert_adr", int'(invert_adr), ld_q.pop_front());
      end
      if (en_rd) begin
        if (rd_q.size() == 0) unexpected("en_rd");
        else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_ptr", int'(rd_ptr), e.ptr);
          check("unload", int'(unload), int'(e.unl));
          if (!e.unl) begin
            check("tw_adr", int'(tw_adr), e.tw);
            check("stage", int'(stage), e.stg);
          end
        end
      end
      if (en_wr) begin
        if (wr_q.size() == 0) unexpected("en_wr");
        else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_ptr", int'(wr_ptr), w.ptr);
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // Expected schedule after the last sample at cycle last: stage s occupies
  // 16 read cycles + 4 drain cycles, then 16 unload reads, then done.
  task automatic push_calc(input int last);
    int k;
    int span;
    for (int s = 0; s < SIZE; s++) begin
      span = 1 << s;
      k = 0;
      for (int g = 0; g < N; g += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          rd_q.push_back('{g + p, p * (N / (2 * span)), s, 1'b0, last + 1 + 20 * s + k});
          wr_q.push_back('{g + p, last + 4 + 20 * s + k});
          k++;
          rd_q.push_back('{g + p + span, p * (N / (2 * span)), s, 1'b0, last + 1 + 20 * s + k});
          wr_q.push_back('{g + p + span, last + 4 + 20 * s + k});
          k++;
        end
      end
    end
    for (int u = 0; u < N; u++) rd_q.push_back('{u, 0, 0, 1'b1, last + 81 + u});
    done_q.push_back(last + 97);
  endtask

  task automatic load_and_queue(input bit gaps, output int last);
    last = 0;
    foreach (bitrev_tab[i]) ld_q.push_back(bitrev_tab[i]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      if (i == N - 1) begin
        last = cyc;
        push_calc(last);
      end
      @(posedge clk); #1;
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_data"}, int'(load_data), 0);
    check({tag, "_invert_adr"}, int'(invert_adr), 0);
    check({tag, "_en_rd"}, int'(en_rd), 0);
    check({tag, "_rd_ptr"}, int'(rd_ptr), 0);
    check({tag, "_en_wr"}, int'(en_wr), 0);
    check({tag, "_wr_ptr"}, int'(wr_ptr), 0);
    check({tag, "_tw_adr"}, int'(tw_adr), 0);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_unload"}, int'(unload), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int last;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray in_valid while IDLE must not load anything.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_busy", int'(busy), 0);

    // Scenarios 1-4: back-to-back load, full transform.
    load_and_queue(1'b0, last);
    check("busy_in_calc", int'(busy), 1);
    wait_until(last + 100);
    check("idle_after_run1", int'(busy), 0);

    // Scenario 5: gapped load, start and in_valid during CALC.
    load_and_queue(1'b1, last);
    wait_until(last + 10);
    start    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_until(last + 100);
    check("idle_after_run2", int'(busy), 0);

    // Scenario 6: reset during stage 2 CALC with write-backs in flight.
    load_and_queue(1'b0, last);
    wait_until(last + 45);
    check("stage2_before_reset", int'(stage), 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    ld_q.delete();
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_and_queue(1'b0, last);
    wait_until(last + 100);
    check("idle_after_run3", int'(busy), 0);

    check("ld_q_left", ld_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    check("done_q_left", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
